opll_wr_scheduler: RTL and testbench

//  Shares one OPLL (YM2413) core between the two FM-PAC cart instances.
//  - Captures each cart's OPLL register writes (opll_wr strobes) in a per-source FIFO.
//  - Round-robin arbitrates between the sources.
//  - Issues writes to the OPLL only after the chip's address/data recovery time.
//  - Sits between cart_fm_pac (opll_wr[1:0], opll_io_enable[1:0]) and the OPLL instance.

---
 rtl/opll_wr_scheduler.sv | 146 ++++++++++++++
 tb/tb_opll_wr_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/opll_wr_scheduler.sv
// Shares one OPLL core between two cart sources: per-source write FIFOs, round-robin grant, recovery-time pacing.
// Latency: strobe at edge N -> opll_wr high in cycle N+2 when idle; pulses spaced >= wait+2 cycles.
// Backpressure: none upstream; full FIFO drops the write and sets overflow[n]. OPLL_WR_STATS_EN adds drop_cnt.
module opll_wr_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84,
  parameter int WAIT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  src_wr,
  input  logic [1:0]  src_a0,
  input  logic [15:0] src_din,
  input  logic [1:0]  src_enable,
  input  logic [1:0]  clr_overflow,
  output logic        opll_wr,
  output logic        opll_a0,
  output logic [7:0]  opll_dout,
  output logic        busy,
  output logic [1:0]  overflow
`ifdef OPLL_WR_STATS_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [PW-1:0]     wr_ptr [2];
  logic [PW-1:0]     rd_ptr [2];
  logic [8:0]        mem [2][FIFO_DEPTH];
  logic [1:0]        fifo_empty, fifo_full, push, pop, drop;
  logic              rr_ptr;
  logic              grant_vld;
  logic              grant_src;

  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    push       = '0;
    drop       = '0;
    for (int n = 0; n < 2; n++) begin
      fifo_empty[n] = (wr_ptr[n] == rd_ptr[n]);
      fifo_full[n]  = (wr_ptr[n][PW-1] != rd_ptr[n][PW-1]) &&
                      (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
      // A pop on the same edge frees a slot, so a full FIFO can still accept.
      push[n] = src_wr[n] & src_enable[n] & (~fifo_full[n] | pop[n]);
      drop[n] = src_wr[n] & src_enable[n] & fifo_full[n] & ~pop[n];
    end
  end

  always_comb begin
    grant_vld = (state == IDLE) && (fifo_empty != 2'b11);
    grant_src = rr_ptr;
    case (~fifo_empty)
      2'b01:   grant_src = 1'b0;
      2'b10:   grant_src = 1'b1;
      default: grant_src = rr_ptr;
    endcase
    pop = grant_vld ? (2'b01 << grant_src) : 2'b00;
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: if (grant_vld) state_nxt = ISSUE;
      ISSUE: begin
        wait_cnt_nxt = opll_a0 ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);
        state_nxt    = WAIT;
      end
      WAIT: begin
        // A zero load still spends one cycle here.
        if (wait_cnt <= WAIT_W'(1)) begin
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign opll_wr = (state == ISSUE);
  assign busy    = (state != IDLE) || (fifo_empty != 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rr_ptr    <= 1'b0;
      opll_a0   <= 1'b0;
      opll_dout <= '0;
      overflow  <= '0;
      for (int n = 0; n < 2; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
      end
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (grant_vld) begin
        rr_ptr               <= ~grant_src;
        {opll_a0, opll_dout} <= mem[grant_src][rd_ptr[grant_src][AW-1:0]];
      end
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + PW'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PW'(1);
        if (drop[n])              overflow[n] <= 1'b1;
        else if (clr_overflow[n]) overflow[n] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem[n][wr_ptr[n][AW-1:0]] <= {src_a0[n], src_din[8*n +: 8]};
    end
  end

`ifdef OPLL_WR_STATS_EN
  logic [7:0] drop_cnt_r [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_r[0] <= '0;
      drop_cnt_r[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (clr_overflow[n])                         drop_cnt_r[n] <= '0;
        else if (drop[n] && drop_cnt_r[n] != 8'hFF)  drop_cnt_r[n] <= drop_cnt_r[n] + 8'd1;
      end
    end
  end

  assign drop_cnt = {drop_cnt_r[1], drop_cnt_r[0]};
`endif

endmodule

// File: tb/tb_opll_wr_scheduler.sv
// Scoreboard bench for opll_wr_scheduler: a queue-based reference model predicts every OPLL write and its cycle.
module tb_opll_wr_scheduler;
  localparam int DEPTH = 4;
  localparam int AWT   = 12;
  localparam int DWT   = 84;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  src_wr = '0, src_a0 = '0, src_enable = '0, clr_overflow = '0;
  logic [15:0] src_din = '0;
  logic        opll_wr, opll_a0, busy;
  logic [7:0]  opll_dout;
  logic [1:0]  overflow;
`ifdef OPLL_WR_STATS_EN
  logic [15:0] drop_cnt;
`endif

  opll_wr_scheduler #(.FIFO_DEPTH(DEPTH), .ADDR_WAIT(AWT), .DATA_WAIT(DWT), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .src_wr(src_wr), .src_a0(src_a0), .src_din(src_din),
    .src_enable(src_enable), .clr_overflow(clr_overflow), .opll_wr(opll_wr),
    .opll_a0(opll_a0), .opll_dout(opll_dout), .busy(busy), .overflow(overflow)
`ifdef OPLL_WR_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic a0; logic [7:0] d; int at; } exp_t;
  exp_t sb[$];

  // Reference model: plain per-source queues plus the earliest cycle a new grant may happen.
  logic [8:0] mq0[$];
  logic [8:0] mq1[$];
  int         next_grant = 0;
  int         last_src = 1;
  bit         model_ok = 0;
  logic [1:0] m_ov = '0;
  logic [7:0] m_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hold(input logic a0);
    int w;
    w = a0 ? DWT : AWT;
    return (w < 1) ? 1 : w;
  endfunction

  task automatic step(input logic rst, input logic [1:0] wr, input logic [1:0] a0,
                      input logic [15:0] din, input logic [1:0] en, input logic [1:0] clr);
    int c;
    int g;
    logic [8:0] h;
    logic [1:0] dropped;
    exp_t e;
    @(negedge clk);
    c = cyc;
    if (model_ok) begin
      chk("busy", busy, (mq0.size() != 0 || mq1.size() != 0 || c < next_grant));
      chk("overflow", overflow, m_ov);
`ifdef OPLL_WR_STATS_EN
      chk("drop_cnt", drop_cnt, {m_cnt[1], m_cnt[0]});
`endif
    end
    reset = rst; src_wr = wr; src_a0 = a0; src_din = din; src_enable = en; clr_overflow = clr;
    if (rst) begin
      mq0.delete(); mq1.delete();
      next_grant = 0; last_src = 1; m_ov = '0; m_cnt[0] = '0; m_cnt[1] = '0;
      model_ok = 1;
    end else begin
      if (c >= next_grant && (mq0.size() != 0 || mq1.size() != 0)) begin
        if (mq0.size() != 0 && mq1.size() != 0) g = (last_src == 0) ? 1 : 0;
        else g = (mq0.size() != 0) ? 0 : 1;
        h = (g == 1) ? mq1.pop_front() : mq0.pop_front();
        e.a0 = h[8]; e.d = h[7:0]; e.at = c + 1;
        sb.push_back(e);
        last_src = g;
        next_grant = c + hold(h[8]) + 2;
      end
      dropped = '0;
      if (wr[0] && en[0]) begin
        if (mq0.size() < DEPTH) mq0.push_back({a0[0], din[7:0]});
        else dropped[0] = 1'b1;
      end
      if (wr[1] && en[1]) begin
        if (mq1.size() < DEPTH) mq1.push_back({a0[1], din[15:8]});
        else dropped[1] = 1'b1;
      end
      for (int n = 0; n < 2; n++) begin
        if (dropped[n]) m_ov[n] = 1'b1;
        else if (clr[n]) m_ov[n] = 1'b0;
        if (clr[n]) m_cnt[n] = '0;
        else if (dropped[n] && m_cnt[n] != 8'hFF) m_cnt[n] = m_cnt[n] + 8'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 16'h0000, 2'b11, 2'b00);
  endtask

  exp_t got;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at < cyc) begin
      checks++; errs++;
      $display("FAIL missed_wr: no opll_wr at cycle %0d, expected dout %0h", sb[0].at, sb[0].d);
      void'(sb.pop_front());
    end
    if (opll_wr === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL spurious_wr: opll_wr with dout %0h at cycle %0d, none expected", opll_dout, cyc);
      end else begin
        got = sb.pop_front();
        chk("wr_cycle", cyc, got.at);
        chk("wr_a0", opll_a0, got.a0);
        chk("wr_dout", opll_dout, got.d);
      end
    end
  end

  initial begin
    m_cnt[0] = '0; m_cnt[1] = '0;
    step(1'b1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00);
    step(1'b1, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00);
    @(negedge clk);
    chk("reset_wr", opll_wr, 1'b0);
    chk("reset_a0", opll_a0, 1'b0);
    chk("reset_dout", opll_dout, 8'h00);
    idle(2);
    // single address write, then address/data back to back
    step(1'b0, 2'b01, 2'b00, 16'h0010, 2'b11, 2'b00); idle(30);
    step(1'b0, 2'b01, 2'b00, 16'h0020, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b01, 16'h0055, 2'b11, 2'b00); idle(110);
    // simultaneous pairs alternate sources
    step(1'b0, 2'b11, 2'b00, 16'hB1A1, 2'b11, 2'b00); idle(40);
    step(1'b0, 2'b11, 2'b00, 16'hB2A2, 2'b11, 2'b00); idle(40);
    // src1 burst during a long wait overflows the FIFO
    step(1'b0, 2'b01, 2'b01, 16'h0033, 2'b11, 2'b00); idle(3);
    for (int k = 1; k <= 6; k++) step(1'b0, 2'b10, 2'b00, 16'(k << 12 | k << 8), 2'b11, 2'b00);
    idle(2);
    step(1'b0, 2'b00, 2'b00, 16'h0000, 2'b11, 2'b10); idle(200);
    // disabled source is ignored
    step(1'b0, 2'b10, 2'b00, 16'h7700, 2'b01, 2'b00); idle(5);
    // reset during wait discards queued writes
    step(1'b0, 2'b01, 2'b01, 16'h0044, 2'b11, 2'b00); idle(4);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b10, 2'b00, 16'(16'h9000 + (k << 8)), 2'b11, 2'b00);
    idle(2);
    step(1'b1, 2'b00, 2'b00, 16'h0000, 2'b11, 2'b00);
    step(1'b0, 2'b01, 2'b00, 16'h0066, 2'b11, 2'b00); idle(20);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 999) == 0),
           {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
           2'($urandom), 16'($urandom),
           ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11,
           ($urandom_range(0, 49) == 0) ? 2'($urandom) : 2'b00);
    end
    idle(800);
    chk("sb_drained", sb.size(), 0);
    chk("model_q0_empty", mq0.size(), 0);
    chk("model_q1_empty", mq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
